// File: rtl/csr_pkg.sv
// Shared types and constants for the machine-mode CSR unit.
// The optional mcycle counter addresses are only decoded when CSR_CYCLE_COUNTER_EN is defined.
package csr_pkg;

    typedef enum logic [2:0] {
        OP_RW  = 3'b000,
        OP_RS  = 3'b001,
        OP_RC  = 3'b010,
        OP_RWI = 3'b011,
        OP_RSI = 3'b100,
        OP_RCI = 3'b101
    } csr_op_t;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam int CAUSE_W = 4;
    localparam logic [CAUSE_W-1:0] CAUSE_MSI = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_MTI = 4'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_MEI = 4'd11;

endpackage

// File: rtl/csr_irq_arbiter.sv
// Interrupt priority select and request/acknowledge handshake with the pipeline.
// Once a request is raised, its cause stays frozen until the pipeline acknowledges it.
module csr_irq_arbiter
    import csr_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pend_mei,
    input  logic               pend_msi,
    input  logic               pend_mti,
    input  logic               irq_ack,
    output logic               irq_req,
    output logic [CAUSE_W-1:0] cause,
    output logic               take
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state_q;
    logic               irq_req_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [CAUSE_W-1:0] sel_cause;
    logic               any_pending;

    assign any_pending = pend_mei | pend_msi | pend_mti;

    // External beats software beats timer.
    always_comb begin
        sel_cause = CAUSE_MTI;
        if (pend_mei) begin
            sel_cause = CAUSE_MEI;
        end else if (pend_msi) begin
            sel_cause = CAUSE_MSI;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
            cause_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_pending) begin
                        state_q   <= PEND;
                        irq_req_q <= 1'b1;
                        cause_q   <= sel_cause;
                    end
                end
                PEND: begin
                    if (irq_ack) begin
                        state_q   <= IDLE;
                        irq_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req = irq_req_q;
    assign cause   = cause_q;
    assign take    = (state_q == PEND) && irq_ack;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage, read-modify-write execution, trap entry and mret redirect.
// Define CSR_CYCLE_COUNTER_EN to add the 64-bit mcycle counter at 0xB00/0xB80.
module csr_regfile
    import csr_pkg::*;
#(
    parameter int             DW        = 32,
    parameter int             ADDRW     = 12,
    parameter logic [DW-1:0]  MTVEC_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_valid,
    input  logic [2:0]       csr_cntr,
    input  logic [ADDRW-1:0] csr_addr,
    input  logic [DW-1:0]    rs1_data,
    input  logic [4:0]       zimm,
    input  logic             src_zero,
    input  logic [DW-1:0]    pc_in,
    input  logic             is_mret,
    input  logic             ext_irq,
    input  logic             timer_irq,
    input  logic             irq_ack,
    output logic [DW-1:0]    csr_rdata,
    output logic             illegal,
    output logic             irq_req,
    output logic             redirect,
    output logic [DW-1:0]    redirect_pc
);

    localparam logic [DW-1:0] MSTATUS_WMASK = (DW'(1) << MSTATUS_MIE) | (DW'(1) << MSTATUS_MPIE);
    localparam logic [DW-1:0] MIE_WMASK     = (DW'(1) << MIE_MSIE) | (DW'(1) << MIE_MTIE) |
                                              (DW'(1) << MIE_MEIE);
    localparam logic [DW-1:0] MEPC_WMASK    = ~DW'(3);

    logic [DW-1:0] mstatus_q, mstatus_d;
    logic [DW-1:0] mie_q, mie_d;
    logic          msip_q, msip_d;
    logic [DW-1:0] mtvec_q, mtvec_d;
    logic [DW-1:0] mepc_q, mepc_d;
    logic [DW-1:0] mcause_q, mcause_d;
    logic [DW-1:0] mscratch_q, mscratch_d;
`ifdef CSR_CYCLE_COUNTER_EN
    logic [63:0]   mcycle_q, mcycle_d;
`endif

    logic [DW-1:0]      mip_val;
    logic [DW-1:0]      rdata;
    logic               addr_hit;
    logic [DW-1:0]      src;
    logic [DW-1:0]      wval;
    logic               op_valid;
    logic               set_clr;
    logic               we;
    logic               take;
    logic [CAUSE_W-1:0] cause;
    logic [DW-1:0]      trap_cause;
    logic [DW-1:0]      trap_base;
    logic [DW-1:0]      trap_target;

    always_comb begin
        mip_val           = '0;
        mip_val[MIP_MSIP] = msip_q;
        mip_val[MIP_MTIP] = timer_irq;
        mip_val[MIP_MEIP] = ext_irq;
    end

    always_comb begin
        rdata    = '0;
        addr_hit = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:  rdata = mstatus_q;
            ADDR_MIE:      rdata = mie_q;
            ADDR_MTVEC:    rdata = mtvec_q;
            ADDR_MSCRATCH: rdata = mscratch_q;
            ADDR_MEPC:     rdata = mepc_q;
            ADDR_MCAUSE:   rdata = mcause_q;
            ADDR_MIP:      rdata = mip_val;
`ifdef CSR_CYCLE_COUNTER_EN
            ADDR_MCYCLE:   rdata = mcycle_q[31:0];
            ADDR_MCYCLEH:  rdata = mcycle_q[63:32];
`endif
            default:       addr_hit = 1'b0;
        endcase
    end

    assign csr_rdata = rdata;
    assign illegal   = csr_valid && !addr_hit;

    always_comb begin
        op_valid = 1'b1;
        set_clr  = 1'b0;
        src      = rs1_data;
        wval     = rdata;
        case (csr_cntr)
            OP_RW:  wval = rs1_data;
            OP_RS:  begin wval = rdata | rs1_data;  set_clr = 1'b1; end
            OP_RC:  begin wval = rdata & ~rs1_data; set_clr = 1'b1; end
            OP_RWI: begin src = {{(DW-5){1'b0}}, zimm}; wval = src; end
            OP_RSI: begin src = {{(DW-5){1'b0}}, zimm}; wval = rdata | src;  set_clr = 1'b1; end
            OP_RCI: begin src = {{(DW-5){1'b0}}, zimm}; wval = rdata & ~src; set_clr = 1'b1; end
            default: op_valid = 1'b0;
        endcase
    end

    assign we = csr_valid && addr_hit && op_valid && !(set_clr && src_zero);

    csr_irq_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .pend_mei (mstatus_q[MSTATUS_MIE] & mie_q[MIE_MEIE] & mip_val[MIP_MEIP]),
        .pend_msi (mstatus_q[MSTATUS_MIE] & mie_q[MIE_MSIE] & mip_val[MIP_MSIP]),
        .pend_mti (mstatus_q[MSTATUS_MIE] & mie_q[MIE_MTIE] & mip_val[MIP_MTIP]),
        .irq_ack  (irq_ack),
        .irq_req  (irq_req),
        .cause    (cause),
        .take     (take)
    );

    always_comb begin
        trap_cause                = '0;
        trap_cause[DW-1]          = 1'b1;
        trap_cause[CAUSE_W-1:0]   = cause;
        trap_base                 = {mtvec_q[DW-1:2], 2'b00};
        trap_target               = mtvec_q[0] ? trap_base + (DW'(cause) << 2) : trap_base;
    end

    assign redirect    = rst_n && (take || is_mret);
    assign redirect_pc = take ? trap_target : mepc_q;

    // Trap acceptance overrides mret, which overrides a CSR write to the same fields.
    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        msip_d     = msip_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
`ifdef CSR_CYCLE_COUNTER_EN
        mcycle_d   = mcycle_q + 64'd1;
`endif
        if (we) begin
            case (csr_addr)
                ADDR_MSTATUS:  mstatus_d  = wval & MSTATUS_WMASK;
                ADDR_MIE:      mie_d      = wval & MIE_WMASK;
                ADDR_MTVEC:    mtvec_d    = wval;
                ADDR_MSCRATCH: mscratch_d = wval;
                ADDR_MEPC:     mepc_d     = wval & MEPC_WMASK;
                ADDR_MCAUSE:   mcause_d   = wval;
                ADDR_MIP:      msip_d     = wval[MIP_MSIP];
`ifdef CSR_CYCLE_COUNTER_EN
                ADDR_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wval[31:0]};
                ADDR_MCYCLEH:  mcycle_d   = {wval[31:0], mcycle_q[31:0]};
`endif
                default: ;
            endcase
        end
        if (is_mret) begin
            mstatus_d               = mstatus_q;
            mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE] = 1'b1;
        end
        if (take) begin
            mstatus_d               = mstatus_q;
            mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]  = 1'b0;
            mepc_d                  = pc_in & MEPC_WMASK;
            mcause_d                = trap_cause;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            msip_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
`ifdef CSR_CYCLE_COUNTER_EN
            mcycle_q   <= '0;
`endif
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            msip_q     <= msip_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
`ifdef CSR_CYCLE_COUNTER_EN
            mcycle_q   <= mcycle_d;
`endif
        end
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: vector table, trap/mret sequences, randomized CSR ops.
module tb_csr_regfile;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_valid;
    logic [2:0]  csr_cntr;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        src_zero;
    logic [31:0] pc_in;
    logic        is_mret;
    logic        ext_irq;
    logic        timer_irq;
    logic        irq_ack;
    logic [31:0] csr_rdata;
    logic        illegal;
    logic        irq_req;
    logic        redirect;
    logic [31:0] redirect_pc;

    csr_regfile dut (
        .clk(clk), .rst_n(rst_n), .csr_valid(csr_valid), .csr_cntr(csr_cntr),
        .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm), .src_zero(src_zero),
        .pc_in(pc_in), .is_mret(is_mret), .ext_irq(ext_irq), .timer_irq(timer_irq),
        .irq_ack(irq_ack), .csr_rdata(csr_rdata), .illegal(illegal), .irq_req(irq_req),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] s_rdata, s_rpc;
    logic        s_ill, s_irq, s_red;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic        sz;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;
    vec_t vecs[$];

    // Reference state, kept as plain architectural values.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic        m_msip;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_rdata = csr_rdata;
        s_ill   = illegal;
        s_irq   = irq_req;
        s_red   = redirect;
        s_rpc   = redirect_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        csr_valid = 1'b0; csr_cntr = 3'd0; csr_addr = 12'd0; rs1_data = 32'd0;
        zimm = 5'd0; src_zero = 1'b0; is_mret = 1'b0; irq_ack = 1'b0;
    endtask

    task automatic csr_op(input logic [2:0] op, input logic [11:0] a, input logic [31:0] r,
                          input logic [4:0] z, input logic sz);
        csr_valid = 1'b1; csr_cntr = op; csr_addr = a; rs1_data = r; zimm = z; src_zero = sz;
        step();
        idle_in();
        $display("csr op=%0d addr=0x%03h rs1=0x%08h zimm=%0d sz=%0b -> rdata=0x%08h ill=%0b",
                 op, a, r, z, sz, s_rdata, s_ill);
    endtask

    task automatic rd(input logic [11:0] a);
        csr_op(3'd1, a, 32'd0, 5'd0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0; pc_in = 32'd0;
        idle_in();
        step();
        step();
        rst_n = 1'b1;
        m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_msip = 1'b0;
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [11:0] a, input logic [31:0] r,
                           input logic [4:0] z, input logic sz, input logic [31:0] er,
                           input logic ei);
        vec_t v;
        v.op = op; v.addr = a; v.rs1 = r; v.zimm = z; v.sz = sz; v.exp_rd = er; v.exp_ill = ei;
        vecs.push_back(v);
    endtask

    function automatic bit m_impl(input logic [11:0] a);
        return a inside {A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MIP};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            A_MSTATUS:  return m_mstatus;
            A_MIE:      return m_mie;
            A_MTVEC:    return m_mtvec;
            A_MSCRATCH: return m_mscratch;
            A_MEPC:     return m_mepc;
            A_MCAUSE:   return m_mcause;
            A_MIP:      return m_msip ? 32'h8 : 32'h0;
            default:    return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [2:0] op, input logic [11:0] a, input logic [31:0] r,
                           input logic [4:0] z, input logic sz);
        logic [31:0] srcv, oldv, newv;
        if (!m_impl(a)) return;
        srcv = (op >= 3) ? {27'd0, z} : r;
        oldv = m_read(a);
        if ((op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) && sz) return;
        case (op)
            3'd0, 3'd3: newv = srcv;
            3'd1, 3'd4: newv = oldv | srcv;
            default:    newv = oldv & ~srcv;
        endcase
        case (a)
            A_MSTATUS:  m_mstatus  = newv & 32'h0000_0088;
            A_MIE:      m_mie      = newv & 32'h0000_0888;
            A_MTVEC:    m_mtvec    = newv;
            A_MSCRATCH: m_mscratch = newv;
            A_MEPC:     m_mepc     = newv & 32'hFFFF_FFFC;
            A_MCAUSE:   m_mcause   = newv;
            default:    m_msip     = newv[3];
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] rst_addrs[$];
        logic [11:0] addr_list[$];

        rst_n = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0; pc_in = 32'd0;
        idle_in();
        do_reset();
        check("reset_irq_req", 32'(s_irq), 32'd0);
        check("reset_redirect", 32'(s_red), 32'd0);

        rst_addrs = '{A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MIP};
        foreach (rst_addrs[i]) begin
            rd(rst_addrs[i]);
            check("reset_read", s_rdata, 32'd0);
        end

        add_vec(3'd1, A_MTVEC,    32'h0,        5'd0, 1'b1, 32'h0,        1'b0);
        add_vec(3'd0, A_MSCRATCH, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0,        1'b0);
        add_vec(3'd1, A_MSCRATCH, 32'h10,       5'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        add_vec(3'd1, A_MSCRATCH, 32'h0,        5'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        add_vec(3'd4, A_MSTATUS,  32'h0,        5'd8, 1'b0, 32'h0,        1'b0);
        add_vec(3'd5, A_MSTATUS,  32'h0,        5'd8, 1'b0, 32'h8,        1'b0);
        add_vec(3'd1, A_MSTATUS,  32'h0,        5'd0, 1'b1, 32'h0,        1'b0);
        add_vec(3'd0, 12'h7C0,    32'h1234,     5'd0, 1'b0, 32'h0,        1'b1);
        add_vec(3'd1, 12'h7C0,    32'h0,        5'd0, 1'b1, 32'h0,        1'b1);
        add_vec(3'd1, A_MSCRATCH, 32'h0,        5'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        add_vec(3'd0, A_MEPC,     32'h1237,     5'd0, 1'b0, 32'h0,        1'b0);
        add_vec(3'd1, A_MEPC,     32'h0,        5'd0, 1'b1, 32'h1234,     1'b0);
        add_vec(3'd0, A_MSTATUS,  32'hFFFFFFFF, 5'd0, 1'b0, 32'h0,        1'b0);
        add_vec(3'd0, A_MSTATUS,  32'h0,        5'd0, 1'b0, 32'h88,       1'b0);
        add_vec(3'd0, A_MIE,      32'hFFFFFFFF, 5'd0, 1'b0, 32'h0,        1'b0);
        add_vec(3'd2, A_MIE,      32'h808,      5'd0, 1'b0, 32'h888,      1'b0);
        add_vec(3'd1, A_MIE,      32'h0,        5'd0, 1'b1, 32'h80,       1'b0);
        add_vec(3'd3, A_MSCRATCH, 32'h0,        5'd5, 1'b0, 32'hDEADBEEF, 1'b0);
        add_vec(3'd1, A_MSCRATCH, 32'h0,        5'd0, 1'b1, 32'h5,        1'b0);
        add_vec(3'd4, A_MIP,      32'h0,        5'd8, 1'b0, 32'h0,        1'b0);
        add_vec(3'd5, A_MIP,      32'h0,        5'd8, 1'b0, 32'h8,        1'b0);
        add_vec(3'd1, A_MIP,      32'h0,        5'd0, 1'b1, 32'h0,        1'b0);
        add_vec(3'd0, A_MCAUSE,   32'h8000000B, 5'd0, 1'b0, 32'h0,        1'b0);
        add_vec(3'd1, A_MCAUSE,   32'h0,        5'd0, 1'b1, 32'h8000000B, 1'b0);
        add_vec(3'd0, A_MTVEC,    32'hFFFFFFFF, 5'd0, 1'b0, 32'h0,        1'b0);
        add_vec(3'd1, A_MTVEC,    32'h0,        5'd0, 1'b1, 32'hFFFFFFFF, 1'b0);
`ifndef CSR_CYCLE_COUNTER_EN
        add_vec(3'd0, 12'hB00,    32'h55,       5'd0, 1'b0, 32'h0,        1'b1);
        add_vec(3'd1, 12'hB80,    32'h0,        5'd0, 1'b1, 32'h0,        1'b1);
`endif
        foreach (vecs[i]) begin
            csr_op(vecs[i].op, vecs[i].addr, vecs[i].rs1, vecs[i].zimm, vecs[i].sz);
            check("vec_rdata", s_rdata, vecs[i].exp_rd);
            check("vec_illegal", 32'(s_ill), 32'(vecs[i].exp_ill));
        end

        // External and timer raised together: external wins, direct mode.
        do_reset();
        csr_op(3'd4, A_MSTATUS, 32'h0, 5'd8, 1'b0);
        csr_op(3'd0, A_MIE, 32'h880, 5'd0, 1'b0);
        ext_irq = 1'b1; timer_irq = 1'b1;
        step();
        check("irq_latency", 32'(s_irq), 32'd0);
        step();
        check("irq_req_ext", 32'(s_irq), 32'd1);
        irq_ack = 1'b1; pc_in = 32'h4000_0012;
        step();
        $display("ack: redirect=%0b pc=0x%08h", s_red, s_rpc);
        check("ack_redirect", 32'(s_red), 32'd1);
        check("ack_pc_direct", s_rpc, 32'h0);
        irq_ack = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;
        step();
        check("irq_req_clear", 32'(s_irq), 32'd0);
        rd(A_MCAUSE);  check("mcause_mei", s_rdata, 32'h8000_000B);
        rd(A_MEPC);    check("mepc_saved", s_rdata, 32'h4000_0010);
        rd(A_MSTATUS); check("mstatus_trap", s_rdata, 32'h80);

        // Vectored mode, timer trap, then mret.
        csr_op(3'd0, A_MTVEC, 32'h101, 5'd0, 1'b0);
        csr_op(3'd4, A_MSTATUS, 32'h0, 5'd8, 1'b0);
        timer_irq = 1'b1;
        step();
        step();
        check("irq_req_mti", 32'(s_irq), 32'd1);
        irq_ack = 1'b1; pc_in = 32'h2000;
        step();
        $display("ack: redirect=%0b pc=0x%08h", s_red, s_rpc);
        check("ack_pc_vec_mti", s_rpc, 32'h11C);
        irq_ack = 1'b0; timer_irq = 1'b0;
        rd(A_MCAUSE);  check("mcause_mti", s_rdata, 32'h8000_0007);
        rd(A_MSTATUS); check("mstatus_trap2", s_rdata, 32'h80);
        is_mret = 1'b1;
        step();
        is_mret = 1'b0;
        $display("mret: redirect=%0b pc=0x%08h", s_red, s_rpc);
        check("mret_redirect", 32'(s_red), 32'd1);
        check("mret_pc", s_rpc, 32'h2000);
        rd(A_MSTATUS); check("mstatus_mret", s_rdata, 32'h88);

        // One-cycle external pulse: request and cause held until a late ack.
        ext_irq = 1'b1;
        step();
        ext_irq = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("irq_req_held", 32'(s_irq), 32'd1);
        end
        irq_ack = 1'b1; pc_in = 32'h3000;
        step();
        irq_ack = 1'b0;
        check("ack_pc_vec_mei", s_rpc, 32'h12C);
        rd(A_MCAUSE); check("mcause_held", s_rdata, 32'h8000_000B);

        // Reset while a request is pending, then an ack with nothing pending.
        csr_op(3'd4, A_MSTATUS, 32'h0, 5'd8, 1'b0);
        timer_irq = 1'b1;
        step();
        step();
        check("irq_req_pre_rst", 32'(s_irq), 32'd1);
        do_reset();
        check("irq_req_rst_pend", 32'(s_irq), 32'd0);
        irq_ack = 1'b1; pc_in = 32'h5550;
        step();
        irq_ack = 1'b0;
        check("idle_ack_ignored", 32'(s_red), 32'd0);
        rd(A_MEPC);  check("idle_ack_mepc", s_rdata, 32'h0);
        rd(A_MTVEC); check("mtvec_rst", s_rdata, 32'h0);

        // Randomized CSR traffic against the reference model.
        do_reset();
        addr_list = '{A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MIP, 12'h7C0, 12'h123};
`ifndef CSR_CYCLE_COUNTER_EN
        addr_list.push_back(12'hB00);
`endif
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  op;
            logic [11:0] a;
            logic [31:0] r, exp_rd;
            logic [4:0]  z;
            logic        sz, exp_ill;
            op = 3'($urandom_range(0, 5));
            a  = addr_list[$urandom_range(0, addr_list.size() - 1)];
            r  = $urandom;
            z  = 5'($urandom);
            sz = (op >= 3) ? (z == 5'd0) : ($urandom_range(0, 3) == 0);
            if (op < 3 && sz) r = 32'd0;
            exp_rd  = m_read(a);
            exp_ill = !m_impl(a);
            csr_op(op, a, r, z, sz);
            check("rand_rdata", s_rdata, exp_rd);
            check("rand_illegal", 32'(s_ill), 32'(exp_ill));
            m_write(op, a, r, z, sz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
